// File: rtl/cpu_types_pkg.sv
// Core-wide scalar types shared by the pipeline stages.
package cpu_types_pkg;
   typedef logic [31:0] word_t;
endpackage

// File: rtl/datapath_types_pkg.sv
// Datapath types for branch prediction: counter states, hazard-unit grades,
// and the BTB entry layout for the default 16-entry configuration.
package datapath_types_pkg;
   import cpu_types_pkg::*;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } bp_state_t;

   typedef enum logic [1:0] {
      NA         = 2'b00,
      RIGHT_PRED = 2'b01,
      WRONG_PRED = 2'b10
   } br_pred_t;

   localparam int BTB_DEFAULT_ENTRIES = 16;
   localparam int BTB_DEFAULT_TAGW    = 32 - $clog2(BTB_DEFAULT_ENTRIES) - 2;

   typedef struct packed {
      logic                        valid;
      logic [BTB_DEFAULT_TAGW-1:0] tag;
      word_t                       target;
      bp_state_t                   state;
   } btb_entry_t;
endpackage

// File: rtl/branch_predictor_if.sv
// Port bundle between the predictor, the fetch stage and the execute stage.
interface branch_predictor_if;
   import cpu_types_pkg::*;
   import datapath_types_pkg::*;

   word_t    fetch_pc;
   logic     pred_taken;
   word_t    pred_target;
   logic     pred_hit;
   logic     upd_en;
   br_pred_t upd_result;
   word_t    upd_pc;
   logic     upd_pred_taken;
   word_t    upd_target;
   word_t    branch_cnt;
   word_t    mispred_cnt;

   modport bp (
      input  fetch_pc, upd_en, upd_result, upd_pc, upd_pred_taken, upd_target,
      output pred_taken, pred_target, pred_hit, branch_cnt, mispred_cnt
   );
   modport fetch (
      output fetch_pc,
      input  pred_taken, pred_target, pred_hit
   );
   modport exec (
      output upd_en, upd_result, upd_pc, upd_pred_taken, upd_target,
      input  branch_cnt, mispred_cnt
   );
endinterface

// File: rtl/bp_sat_counter.sv
// Next-state logic of a 2-bit saturating branch counter.
module bp_sat_counter
   import datapath_types_pkg::*;
(
   input  bp_state_t state_i,
   input  logic      actual_i,
   output bp_state_t state_next_o
);

   always_comb begin
      state_next_o = state_i;
      case (state_i)
         STRONG_NT: state_next_o = actual_i ? WEAK_NT  : STRONG_NT;
         WEAK_NT:   state_next_o = actual_i ? WEAK_T   : STRONG_NT;
         WEAK_T:    state_next_o = actual_i ? STRONG_T : WEAK_NT;
         STRONG_T:  state_next_o = actual_i ? STRONG_T : WEAK_T;
         default:   state_next_o = WEAK_NT;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup at fetch,
// training from the execute-stage grade, plus branch/mispredict counters.
module branch_predictor
   import cpu_types_pkg::*;
   import datapath_types_pkg::*;
#(
   parameter int ENTRIES = 16
) (
   input  logic     CLK,
   input  logic     nRST,
   input  word_t    fetch_pc,
   output logic     pred_taken,
   output word_t    pred_target,
   output logic     pred_hit,
   input  logic     upd_en,
   input  br_pred_t upd_result,
   input  word_t    upd_pc,
   input  logic     upd_pred_taken,
   input  word_t    upd_target,
   output word_t    branch_cnt,
   output word_t    mispred_cnt
);

   localparam int IDXW = $clog2(ENTRIES);
   localparam int TAGW = 32 - IDXW - 2;

   typedef struct packed {
      logic            valid;
      logic [TAGW-1:0] tag;
      word_t           target;
      bp_state_t       state;
   } entry_t;

   localparam entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, target: 32'd0, state: WEAK_NT};

   entry_t          btb_q [ENTRIES];
   entry_t          btb_d [ENTRIES];
   word_t           branch_cnt_q, branch_cnt_d;
   word_t           mispred_cnt_q, mispred_cnt_d;

   entry_t          look_s;
   entry_t          upd_entry_s;
   logic [IDXW-1:0] upd_idx_s;
   logic [TAGW-1:0] upd_tag_s;
   logic            upd_fire_s;
   logic            upd_wrong_s;
   logic            upd_actual_s;
   logic            upd_hit_s;
   bp_state_t       sat_next_s;
   logic            unused_s;

   assign unused_s = ^{fetch_pc[1:0], upd_pc[1:0]};

   // Fetch-side lookup sees the registered table only (no update bypass)
   always_comb begin
      look_s   = btb_q[fetch_pc[IDXW+1:2]];
      pred_hit = look_s.valid && (look_s.tag == fetch_pc[31:IDXW+2]);
      pred_taken = pred_hit && look_s.state[1];
      if (pred_hit) begin
         pred_target = look_s.target;
      end else begin
         pred_target = 32'd0;
      end
   end

   assign upd_idx_s    = upd_pc[IDXW+1:2];
   assign upd_tag_s    = upd_pc[31:IDXW+2];
   assign upd_entry_s  = btb_q[upd_idx_s];
   assign upd_fire_s   = upd_en && (upd_result != NA);
   assign upd_wrong_s  = (upd_result == WRONG_PRED);
   assign upd_actual_s = upd_pred_taken ^ upd_wrong_s;
   assign upd_hit_s    = upd_entry_s.valid && (upd_entry_s.tag == upd_tag_s);

   bp_sat_counter u_sat (
      .state_i      (upd_entry_s.state),
      .actual_i     (upd_actual_s),
      .state_next_o (sat_next_s)
   );

   // Training and performance-counter next state
   always_comb begin
      btb_d         = btb_q;
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (upd_fire_s) begin
         branch_cnt_d = branch_cnt_q + 32'd1;
         if (upd_wrong_s) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
         end else begin
            mispred_cnt_d = mispred_cnt_q;
         end
         if (upd_hit_s) begin
            btb_d[upd_idx_s].state = sat_next_s;
            if (upd_actual_s) begin
               btb_d[upd_idx_s].target = upd_target;
            end else begin
               btb_d[upd_idx_s].target = upd_entry_s.target;
            end
         end else if (upd_actual_s) begin
            // taken miss evicts whatever aliased into this slot
            btb_d[upd_idx_s] = '{valid: 1'b1, tag: upd_tag_s, target: upd_target, state: WEAK_T};
         end else begin
            btb_d[upd_idx_s] = upd_entry_s;
         end
      end else begin
         branch_cnt_d = branch_cnt_q;
      end
   end

   // Table and counter state registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb_q[i] <= ENTRY_RST;
         end
         branch_cnt_q  <= 32'd0;
         mispred_cnt_q <= 32'd0;
      end else begin
         btb_q         <= btb_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule
